// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// ----------------------------------------------------------------------------
// Register-file write scoreboard between decode and writeback. Each register
// with an in-flight write has a busy bit. Decode offers one instruction per
// cycle through a valid/ready handshake. The scoreboard refuses an offer that
// has a RAW hazard (a used source is busy) or a WAW hazard (a tracked rd is
// busy). It also refuses a tracked write when the outstanding-write budget is
// already used up. Writeback clears busy bits, and flush clears all of them.
//
// Optional build macro:
//   SCOREBOARD_BYPASS_EN - when defined, a writeback that retires register r in
//                          the current cycle hides busy[r] from the hazard check
//                          and frees its budget slot for the full check. A
//                          dependent instruction can then issue in the
//                          writeback cycle.
//
// Ports:
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   issue_valid_i       decode presents an instruction
//   issue_ready_o       instruction accepted this cycle (combinational)
//   issue_rs1_addr_i    source 1 address      issue_rs1_used_i  rs1 is read
//   issue_rs2_addr_i    source 2 address      issue_rs2_used_i  rs2 is read
//   issue_rd_addr_i     destination address   issue_we_i        rd is written
//   wb_valid_i          writeback retires wb_rd_addr_i this cycle
//   flush_i             discard every pending write
//   busy_o              per-register pending-write vector (bit 0 never set)
//   outstanding_o       number of set busy bits
//   wb_err_o            sticky: writeback hit a non-busy, nonzero register
// ----------------------------------------------------------------------------

`ifndef GP_REG_COUNT
`define GP_REG_COUNT 32
`endif

module rf_scoreboard #(
    parameter int REG_COUNT       = `GP_REG_COUNT,
    parameter int MAX_OUTSTANDING = 4,
    localparam int ADDR_W         = $clog2(REG_COUNT),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [ADDR_W-1:0]    issue_rs1_addr_i,
    input  logic                 issue_rs1_used_i,
    input  logic [ADDR_W-1:0]    issue_rs2_addr_i,
    input  logic                 issue_rs2_used_i,
    input  logic [ADDR_W-1:0]    issue_rd_addr_i,
    input  logic                 issue_we_i,
    input  logic                 wb_valid_i,
    input  logic [ADDR_W-1:0]    wb_rd_addr_i,
    input  logic                 flush_i,
    output logic [REG_COUNT-1:0] busy_o,
    output logic [CNT_W-1:0]     outstanding_o,
    output logic                 wb_err_o
);

    localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [REG_COUNT-1:0] ONE_HOT = REG_COUNT'(1);

    logic [REG_COUNT-1:0] busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;

    logic                 tracked;
    logic                 retiring;
    logic                 wb_stray;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;
    logic [REG_COUNT-1:0] haz_busy;
    logic [CNT_W-1:0]     cnt_eff;
    logic                 rs1_haz;
    logic                 rs2_haz;
    logic                 waw_haz;
    logic                 full;
    logic                 ready;
    logic                 set_en;

    always_comb begin
        // Writes to x0 are not tracked. Because of that, busy[0] never gets set.
        tracked  = issue_valid_i & issue_we_i & (issue_rd_addr_i != '0);
        retiring = wb_valid_i & busy_q[wb_rd_addr_i];
        wb_stray = wb_valid_i & ~busy_q[wb_rd_addr_i] & (wb_rd_addr_i != '0);
        set_mask = ONE_HOT << issue_rd_addr_i;
        clr_mask = ONE_HOT << wb_rd_addr_i;

`ifdef SCOREBOARD_BYPASS_EN
        // A retiring entry is treated as already gone for this cycle's decision.
        haz_busy = retiring ? (busy_q & ~clr_mask) : busy_q;
        cnt_eff  = cnt_q - CNT_W'(retiring);
`else
        haz_busy = busy_q;
        cnt_eff  = cnt_q;
`endif

        rs1_haz = issue_rs1_used_i & haz_busy[issue_rs1_addr_i];
        rs2_haz = issue_rs2_used_i & haz_busy[issue_rs2_addr_i];
        waw_haz = tracked & haz_busy[issue_rd_addr_i];
        full    = (cnt_eff == MAX_CNT);

        ready  = ~rst & ~flush_i & ~rs1_haz & ~rs2_haz & ~waw_haz & ~(full & tracked);
        set_en = issue_valid_i & ready & tracked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (flush_i) begin
            // A writeback in a flush cycle is ignored, so it cannot raise an error.
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            // Clear first, then set. If both hit the same register (possible
            // only with bypass), the set wins and the count stays the same.
            busy_q <= (busy_q & ~(retiring ? clr_mask : '0)) | (set_en ? set_mask : '0);
            case ({set_en, retiring})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (wb_stray) begin
                err_q <= 1'b1;
            end
        end
    end

    assign issue_ready_o = ready;
    assign busy_o        = busy_q;
    assign outstanding_o = cnt_q;
    assign wb_err_o      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard. The bench runs directed scenarios with literal
// expectations, then a randomized phase. A behavioural model in the bench
// (a busy array and a popcount) is compared against the DUT on every falling
// clock edge.
`timescale 1ns/1ps

module tb_rf_scoreboard;

    localparam int REGS = 32;
    localparam int AW   = 5;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [AW-1:0]   issue_rs1_addr_i = '0;
    logic            issue_rs1_used_i = 1'b0;
    logic [AW-1:0]   issue_rs2_addr_i = '0;
    logic            issue_rs2_used_i = 1'b0;
    logic [AW-1:0]   issue_rd_addr_i = '0;
    logic            issue_we_i = 1'b0;
    logic            wb_valid_i = 1'b0;
    logic [AW-1:0]   wb_rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic [REGS-1:0] busy_o;
    logic [CW-1:0]   outstanding_o;
    logic            wb_err_o;

    int checks = 0;
    int errors = 0;

    rf_scoreboard dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_rs1_addr_i (issue_rs1_addr_i),
        .issue_rs1_used_i (issue_rs1_used_i),
        .issue_rs2_addr_i (issue_rs2_addr_i),
        .issue_rs2_used_i (issue_rs2_used_i),
        .issue_rd_addr_i  (issue_rd_addr_i),
        .issue_we_i       (issue_we_i),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_addr_i     (wb_rd_addr_i),
        .flush_i          (flush_i),
        .busy_o           (busy_o),
        .outstanding_o    (outstanding_o),
        .wb_err_o         (wb_err_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_busy [REGS];
    bit m_err = 1'b0;
    bit last_fire = 1'b0;
    bit cmp_en = 1'b0;

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < REGS; r++) n += m_busy[r];
        return n;
    endfunction

    // Busy state as the hazard check sees it.
    function automatic bit m_seen_busy(int r);
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_valid_i && int'(wb_rd_addr_i) == r) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    function automatic bit m_ready();
        bit tracked;
        int cnt;
        if (rst || flush_i) return 1'b0;
        tracked = issue_valid_i && issue_we_i && issue_rd_addr_i != 0;
        cnt = m_count();
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_valid_i && m_busy[wb_rd_addr_i]) cnt--;
`endif
        if (issue_rs1_used_i && m_seen_busy(int'(issue_rs1_addr_i))) return 1'b0;
        if (issue_rs2_used_i && m_seen_busy(int'(issue_rs2_addr_i))) return 1'b0;
        if (tracked && m_seen_busy(int'(issue_rd_addr_i))) return 1'b0;
        if (tracked && cnt >= MAXO) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REGS; r++) m_busy[r] = 1'b0;
            m_err = 1'b0;
            last_fire = 1'b0;
        end else begin
            bit fire;
            bit tracked;
            fire = issue_valid_i && m_ready();
            tracked = issue_we_i && issue_rd_addr_i != 0;
            last_fire = fire;
            if (flush_i) begin
                for (int r = 0; r < REGS; r++) m_busy[r] = 1'b0;
            end else begin
                if (wb_valid_i) begin
                    if (m_busy[wb_rd_addr_i]) m_busy[wb_rd_addr_i] = 1'b0;
                    else if (wb_rd_addr_i != 0) m_err = 1'b1;
                end
                if (fire && tracked) m_busy[issue_rd_addr_i] = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [REGS-1:0] exp_busy;
            bit exp_rdy;
            for (int r = 0; r < REGS; r++) exp_busy[r] = m_busy[r];
            exp_rdy = m_ready();
            checks++;
            if (issue_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL model_ready @%0t: got %b expected %b", $time, issue_ready_o, exp_rdy);
            end
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL model_busy @%0t: got %h expected %h", $time, busy_o, exp_busy);
            end
            checks++;
            if (int'(outstanding_o) != m_count() || $isunknown(outstanding_o)) begin
                errors++;
                $display("FAIL model_outstanding @%0t: got %0d expected %0d", $time, outstanding_o, m_count());
            end
            checks++;
            if (wb_err_o !== m_err) begin
                errors++;
                $display("FAIL model_wb_err @%0t: got %b expected %b", $time, wb_err_o, m_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we);
        issue_valid_i    = v;
        issue_rs1_addr_i = AW'(rs1);
        issue_rs1_used_i = u1;
        issue_rs2_addr_i = AW'(rs2);
        issue_rs2_used_i = u2;
        issue_rd_addr_i  = AW'(rd);
        issue_we_i       = we;
    endtask

    task automatic wb(input bit v, input int rd);
        wb_valid_i   = v;
        wb_rd_addr_i = AW'(rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        issue(1, 0, 1, 0, 0, 5, 1);
        #1;
        lit("reset_ready", 32'(issue_ready_o), 32'd0);
        lit("reset_busy", busy_o, 32'h0);
        lit("reset_outstanding", 32'(outstanding_o), 32'd0);
        lit("reset_wb_err", 32'(wb_err_o), 32'd0);
        @(posedge clk);
        cmp_en = 1'b1;
        #1 rst = 1'b0;

        // addi x5: accepted immediately, busy next cycle
        #1 lit("addi_x5_ready", 32'(issue_ready_o), 32'd1);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 0);
        #1;
        lit("addi_x5_busy", busy_o, 32'h0000_0020);
        lit("addi_x5_outstanding", 32'(outstanding_o), 32'd1);

        // RAW consumer of x5
        issue(1, 5, 1, 0, 0, 6, 1);
        #1 lit("raw_stall", 32'(issue_ready_o), 32'd0);
        cyc();
        wb(1, 5);
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        lit("raw_wb_cycle_bypass", 32'(issue_ready_o), 32'd1);
        cyc();
        wb(0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
`else
        lit("raw_wb_cycle", 32'(issue_ready_o), 32'd0);
        cyc();
        wb(0, 0);
        #1 lit("raw_after_wb", 32'(issue_ready_o), 32'd1);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 0);
`endif
        #1;
        lit("raw_busy_x6", busy_o, 32'h0000_0040);
        lit("raw_outstanding", 32'(outstanding_o), 32'd1);
        wb(1, 6);
        cyc();
        wb(0, 0);

        // Fill the budget with x1..x4
        for (int r = 1; r <= 4; r++) begin
            issue(1, 0, 0, 0, 0, r, 1);
            cyc();
        end
        issue(1, 0, 0, 0, 0, 6, 1);
        #1;
        lit("full_stall", 32'(issue_ready_o), 32'd0);
        lit("full_outstanding", 32'(outstanding_o), 32'd4);
        issue(1, 0, 0, 0, 0, 6, 0);
        #1 lit("full_untracked_ready", 32'(issue_ready_o), 32'd1);
        cyc();
        issue(1, 0, 0, 0, 0, 6, 1);
        wb(1, 2);
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        lit("full_wb_cycle_bypass", 32'(issue_ready_o), 32'd1);
        cyc();
        wb(0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
`else
        lit("full_wb_cycle", 32'(issue_ready_o), 32'd0);
        cyc();
        wb(0, 0);
        #1 lit("full_after_wb", 32'(issue_ready_o), 32'd1);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 0);
`endif
        #1;
        lit("full_busy", busy_o, 32'h0000_005A);
        lit("full_outstanding_after", 32'(outstanding_o), 32'd4);

        // Flush with a valid issue
        issue(1, 0, 0, 0, 0, 7, 1);
        flush_i = 1'b1;
        #1 lit("flush_ready", 32'(issue_ready_o), 32'd0);
        cyc();
        flush_i = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);
        #1;
        lit("flush_busy", busy_o, 32'h0);
        lit("flush_outstanding", 32'(outstanding_o), 32'd0);

        // x0 destination and sources
        issue(1, 0, 1, 0, 1, 0, 1);
        #1 lit("x0_ready", 32'(issue_ready_o), 32'd1);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 0);
        wb(1, 0);
        #1 lit("x0_busy", busy_o, 32'h0);
        cyc();
        wb(0, 0);
        #1 lit("x0_wb_err", 32'(wb_err_o), 32'd0);

        // Stray writeback, sticky through flush
        wb(1, 7);
        cyc();
        wb(0, 0);
        #1 lit("stray_wb_err", 32'(wb_err_o), 32'd1);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1 lit("stray_err_after_flush", 32'(wb_err_o), 32'd1);

        // Asynchronous reset in the middle of a stall
        issue(1, 0, 0, 0, 0, 1, 1);
        cyc();
        issue(1, 1, 1, 0, 0, 2, 1);
        #1 lit("pre_rst_stall", 32'(issue_ready_o), 32'd0);
        cyc();
        rst = 1'b1;
        #1;
        lit("rst_busy", busy_o, 32'h0);
        lit("rst_outstanding", 32'(outstanding_o), 32'd0);
        lit("rst_ready", 32'(issue_ready_o), 32'd0);
        lit("rst_wb_err", 32'(wb_err_o), 32'd0);
        cyc();
        rst = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);

        // Randomized phase. Decode holds its inputs stable until they fire.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (rst) begin
                if ($urandom_range(2) == 0) rst = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                rst = 1'b1;
            end
            flush_i = ($urandom_range(29) == 0);
            wb($urandom_range(1), int'($urandom_range(7)));
            if (!issue_valid_i || last_fire) begin
                issue($urandom_range(3) != 0,
                      int'($urandom_range(7)), $urandom_range(1),
                      int'($urandom_range(7)), $urandom_range(1),
                      int'($urandom_range(7)), $urandom_range(3) != 0);
            end
        end
        cyc();
        rst = 1'b0;
        flush_i = 1'b0;
        wb(0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
